// File: rtl/multicycle_pkg.sv
// rtl/multicycle_pkg.sv - shared types and constants for the multi-cycle RV32I control path
package multicycle_pkg;

    // FSM state encoding, exposed on state_dbg
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_JAL    = 4'd10,
        S_JALR   = 4'd11,
        S_JALR2  = 4'd12,
        S_LUI    = 4'd13,
        S_AUIPC  = 4'd14,
        S_TRAP   = 4'd15
    } state_t;

    // Major opcodes, IR[6:0]
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // Operation class handed from the FSM to the ALU decoder
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'd0,
        ALUOP_SUB   = 2'd1,
        ALUOP_RTYPE = 2'd2,
        ALUOP_ITYPE = 2'd3
    } alu_op_t;

    // ALU control codes
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLTU = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;

    // Operand A select
    localparam logic [1:0] SRC_A_PC    = 2'b00;
    localparam logic [1:0] SRC_A_OLDPC = 2'b01;
    localparam logic [1:0] SRC_A_RS1   = 2'b10;
    localparam logic [1:0] SRC_A_ZERO  = 2'b11;

    // Operand B select
    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_IMM  = 2'b01;
    localparam logic [1:0] SRC_B_FOUR = 2'b10;

    // Result bus select
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MDR    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    // funct3 010 and 011 are not branch encodings
    function automatic logic branch_legal(input logic [2:0] funct3);
        return funct3[2:1] != 2'b01;
    endfunction

    // Branch condition from the ALU flags of rs1 - rs2
    function automatic logic branch_taken(input logic [2:0] funct3, input logic zero,
                                          input logic lt, input logic ltu);
        logic taken;
        case (funct3)
            3'b000:  taken = zero;
            3'b001:  taken = !zero;
            3'b100:  taken = lt;
            3'b101:  taken = !lt;
            3'b110:  taken = ltu;
            3'b111:  taken = !ltu;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - maps operation class, funct3 and funct7b5 to an ALU control code
module alu_decoder
    import multicycle_pkg::*;
(
    input  alu_op_t    alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    output logic [3:0] alu_ctrl
);

    // funct7b5 means SUB only for register ops, but SRA for both register and immediate shifts
    always_comb begin
        alu_ctrl = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_ctrl = ALU_ADD;
            ALUOP_SUB: alu_ctrl = ALU_SUB;
            default: begin
                case (funct3)
                    3'b000:  alu_ctrl = (alu_op == ALUOP_RTYPE && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_ctrl = ALU_SLL;
                    3'b010:  alu_ctrl = ALU_SLT;
                    3'b011:  alu_ctrl = ALU_SLTU;
                    3'b100:  alu_ctrl = ALU_XOR;
                    3'b101:  alu_ctrl = funct7b5 ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_ctrl = ALU_OR;
                    default: alu_ctrl = ALU_AND;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - main control FSM of the multi-cycle RV32I core
module multicycle_ctrl
    import multicycle_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             funct7b5,
    input  logic             alu_zero,
    input  logic             alu_lt,
    input  logic             alu_ltu,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             adr_src,
    output logic             ir_write,
    output logic             pc_write,
    output logic             reg_write,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       result_src,
    output logic [3:0]       alu_ctrl,
    output logic             retire,
    output logic             trap,
    output logic [3:0]       state_dbg,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t  state;
    state_t  state_next;
    alu_op_t alu_op;
    logic    trap_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; memory states hold until mem_ready
    always_comb begin
        state_next = state;
        case (state)
            S_FETCH:  if (mem_ready) state_next = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: state_next = S_MEMADR;
                    OP_RTYPE:          state_next = S_EXECR;
                    OP_ITYPE:          state_next = S_EXECI;
                    OP_BRANCH:         state_next = S_BRANCH;
                    OP_JAL:            state_next = S_JAL;
                    OP_JALR:           state_next = S_JALR;
                    OP_LUI:            state_next = S_LUI;
                    OP_AUIPC:          state_next = S_AUIPC;
                    default:           state_next = S_TRAP;
                endcase
            end
            S_MEMADR: state_next = opcode[5] ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (mem_ready) state_next = S_MEMWB;
            S_MEMWB:  state_next = S_FETCH;
            S_MEMWR:  if (mem_ready) state_next = S_FETCH;
            S_EXECR:  state_next = S_ALUWB;
            S_EXECI:  state_next = S_ALUWB;
            S_ALUWB:  state_next = S_FETCH;
            S_BRANCH: state_next = branch_legal(funct3) ? S_FETCH : S_TRAP;
            S_JAL:    state_next = S_ALUWB;
            S_JALR:   state_next = S_JALR2;
            S_JALR2:  state_next = S_ALUWB;
            S_LUI:    state_next = S_ALUWB;
            S_AUIPC:  state_next = S_ALUWB;
            default:  state_next = S_TRAP;
        endcase
    end

    // Datapath controls; everything is held at zero while rst is asserted
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        retire     = 1'b0;
        alu_src_a  = SRC_A_PC;
        alu_src_b  = SRC_B_RS2;
        result_src = RES_ALUOUT;
        alu_op     = ALUOP_ADD;
        if (!rst) begin
            case (state)
                S_FETCH: begin
                    mem_req    = 1'b1;
                    alu_src_b  = SRC_B_FOUR;
                    result_src = RES_ALU;
                    ir_write   = mem_ready;
                    pc_write   = mem_ready;
                end
                S_DECODE: begin
                    alu_src_a = SRC_A_OLDPC;
                    alu_src_b = SRC_B_IMM;
                end
                S_MEMADR: begin
                    alu_src_a = SRC_A_RS1;
                    alu_src_b = SRC_B_IMM;
                end
                S_MEMRD: begin
                    mem_req = 1'b1;
                    adr_src = 1'b1;
                end
                S_MEMWB: begin
                    result_src = RES_MDR;
                    reg_write  = 1'b1;
                    retire     = 1'b1;
                end
                S_MEMWR: begin
                    mem_req = 1'b1;
                    mem_we  = 1'b1;
                    adr_src = 1'b1;
                    retire  = mem_ready;
                end
                S_EXECR: begin
                    alu_src_a = SRC_A_RS1;
                    alu_src_b = SRC_B_RS2;
                    alu_op    = ALUOP_RTYPE;
                end
                S_EXECI: begin
                    alu_src_a = SRC_A_RS1;
                    alu_src_b = SRC_B_IMM;
                    alu_op    = ALUOP_ITYPE;
                end
                S_ALUWB: begin
                    reg_write = 1'b1;
                    retire    = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a = SRC_A_RS1;
                    alu_src_b = SRC_B_RS2;
                    alu_op    = ALUOP_SUB;
                    if (branch_legal(funct3)) begin
                        pc_write = branch_taken(funct3, alu_zero, alu_lt, alu_ltu);
                        retire   = 1'b1;
                    end
                end
                S_JAL, S_JALR2: begin
                    pc_write  = 1'b1;
                    alu_src_a = SRC_A_OLDPC;
                    alu_src_b = SRC_B_FOUR;
                end
                S_JALR: begin
                    alu_src_a = SRC_A_RS1;
                    alu_src_b = SRC_B_IMM;
                end
                S_LUI: begin
                    alu_src_a = SRC_A_ZERO;
                    alu_src_b = SRC_B_IMM;
                end
                S_AUIPC: begin
                    alu_src_a = SRC_A_OLDPC;
                    alu_src_b = SRC_B_IMM;
                end
                default: begin
                end
            endcase
        end
    end

    alu_decoder u_alu_decoder (
        .alu_op   (alu_op),
        .funct3   (funct3),
        .funct7b5 (funct7b5),
        .alu_ctrl (alu_ctrl)
    );

    // Sticky trap flag, raised as the FSM enters TRAP and cleared only by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            trap_q <= 1'b0;
        end else if (state_next == S_TRAP) begin
            trap_q <= 1'b1;
        end
    end

    // Free-running cycle and retired-instruction counters, both wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + CNT_ONE;
            if (retire) begin
                instret_cnt <= instret_cnt + CNT_ONE;
            end
        end
    end

    assign trap      = trap_q;
    assign state_dbg = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - directed self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;
    import multicycle_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        alu_zero;
    logic        alu_lt;
    logic        alu_ltu;
    logic        mem_ready;
    logic        mem_req;
    logic        mem_we;
    logic        adr_src;
    logic        ir_write;
    logic        pc_write;
    logic        reg_write;
    logic [1:0]  alu_src_a;
    logic [1:0]  alu_src_b;
    logic [1:0]  result_src;
    logic [3:0]  alu_ctrl;
    logic        retire;
    logic        trap;
    logic [3:0]  state_dbg;
    logic [31:0] cycle_cnt;
    logic [31:0] instret_cnt;
    logic [5:0]  strobes;

    int checks   = 0;
    int failures = 0;
    logic [31:0] c0;
    logic [31:0] i0;

    multicycle_ctrl #(.CNT_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .opcode      (opcode),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .alu_zero    (alu_zero),
        .alu_lt      (alu_lt),
        .alu_ltu     (alu_ltu),
        .mem_ready   (mem_ready),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .adr_src     (adr_src),
        .ir_write    (ir_write),
        .pc_write    (pc_write),
        .reg_write   (reg_write),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .result_src  (result_src),
        .alu_ctrl    (alu_ctrl),
        .retire      (retire),
        .trap        (trap),
        .state_dbg   (state_dbg),
        .cycle_cnt   (cycle_cnt),
        .instret_cnt (instret_cnt)
    );

    always #5 clk = ~clk;

    // {mem_req, mem_we, ir_write, pc_write, reg_write, retire}
    assign strobes = {mem_req, mem_we, ir_write, pc_write, reg_write, retire};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    // ALU decode vectors: opcode, funct3, funct7b5, exec state, expected alu_ctrl
    logic [6:0] v_op  [5] = '{7'b0110011, 7'b0010011, 7'b0010011, 7'b0110011, 7'b0110011};
    logic [2:0] v_f3  [5] = '{3'b000,     3'b000,     3'b101,     3'b101,     3'b010};
    logic       v_f7  [5] = '{1'b1,       1'b1,       1'b1,       1'b0,       1'b0};
    logic [3:0] v_st  [5] = '{4'd6,       4'd7,       4'd7,       4'd6,       4'd6};
    logic [3:0] v_alu [5] = '{4'b0001,    4'b0000,    4'b1001,    4'b1000,    4'b0101};

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        rst = 1'b1; mem_ready = 1'b0; opcode = '0; funct3 = '0; funct7b5 = 1'b0;
        alu_zero = 1'b0; alu_lt = 1'b0; alu_ltu = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_strobes", 32'(strobes), 32'h0);
        check("rst_selects", 32'({adr_src, alu_src_a, alu_src_b, result_src, alu_ctrl}), 32'h0);

        // reset release: FETCH, counters and trap cleared
        rst = 1'b0; #1;
        check("rel_state", 32'(state_dbg), 32'(S_FETCH));
        check("rel_cycle", cycle_cnt, 32'd0);
        check("rel_instret", instret_cnt, 32'd0);
        check("rel_trap", 32'(trap), 32'd0);

        // ADDI x1,x0,5 with mem_ready held high
        opcode = 7'b0010011; funct3 = 3'b000; funct7b5 = 1'b0; mem_ready = 1'b1; #1;
        check("addi_fetch_str", 32'(strobes), 32'b101100);
        check("addi_fetch_sel", 32'({alu_src_a, alu_src_b, result_src}), 32'b00_10_10);
        tick;
        check("addi_decode", 32'({state_dbg, strobes}), 32'({4'd1, 6'b000000}));
        tick;
        check("addi_exec", 32'({state_dbg, alu_src_a, alu_src_b, alu_ctrl}), 32'({4'd7, 2'b10, 2'b01, 4'b0000}));
        tick;
        check("addi_wb", 32'({state_dbg, strobes, result_src}), 32'({4'd8, 6'b000011, 2'b00}));
        tick;
        check("addi_done_state", 32'(state_dbg), 32'(S_FETCH));
        check("addi_instret", instret_cnt, 32'd1);
        check("addi_cycles", cycle_cnt, 32'd4);

        // LW with three wait cycles in both FETCH and MEMRD
        c0 = cycle_cnt;
        opcode = 7'b0000011; funct3 = 3'b010;
        for (int i = 0; i < 4; i++) begin
            mem_ready = (i == 3); #1;
            check("lw_fetch", 32'({state_dbg, mem_req, adr_src, ir_write, reg_write}),
                  32'({4'd0, 1'b1, 1'b0, (i == 3), 1'b0}));
            tick;
        end
        check("lw_decode", 32'(state_dbg), 32'd1);
        tick;
        check("lw_memadr", 32'({state_dbg, alu_src_a, alu_src_b, alu_ctrl, reg_write}),
              32'({4'd2, 2'b10, 2'b01, 4'b0000, 1'b0}));
        tick;
        for (int i = 0; i < 4; i++) begin
            mem_ready = (i == 3); #1;
            check("lw_memrd", 32'({state_dbg, mem_req, mem_we, adr_src, reg_write, retire}),
                  32'({4'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0}));
            tick;
        end
        check("lw_memwb", 32'({state_dbg, strobes, result_src}), 32'({4'd4, 6'b000011, 2'b01}));
        tick;
        check("lw_cycles", cycle_cnt - c0, 32'd11);
        check("lw_instret", instret_cnt, 32'd2);

        // BNE not taken (zero=1), then taken (zero=0)
        opcode = 7'b1100011; funct3 = 3'b001; alu_zero = 1'b1;
        tick; tick;
        check("bne_nt", 32'({state_dbg, strobes, alu_src_a, alu_src_b, alu_ctrl}),
              32'({4'd9, 6'b000001, 2'b10, 2'b00, 4'b0001}));
        tick;
        check("bne_nt_fetch", 32'(state_dbg), 32'(S_FETCH));
        alu_zero = 1'b0;
        tick; tick;
        check("bne_t", 32'({state_dbg, strobes}), 32'({4'd9, 6'b000101}));
        tick;
        check("bne_instret", instret_cnt, 32'd4);

        // JALR: only one pc_write after FETCH, in JALR2
        opcode = 7'b1100111; funct3 = 3'b000; #1;
        check("jalr_fetch_pcw", 32'(pc_write), 32'd1);
        tick;
        check("jalr_decode", 32'({state_dbg, pc_write}), 32'({4'd1, 1'b0}));
        tick;
        check("jalr_1", 32'({state_dbg, pc_write, alu_src_a, alu_src_b}), 32'({4'd11, 1'b0, 2'b10, 2'b01}));
        tick;
        check("jalr_2", 32'({state_dbg, pc_write, alu_src_a, alu_src_b, result_src}),
              32'({4'd12, 1'b1, 2'b01, 2'b10, 2'b00}));
        tick;
        check("jalr_wb", 32'({state_dbg, strobes}), 32'({4'd8, 6'b000011}));
        tick;
        check("jalr_instret", instret_cnt, 32'd5);

        // R/I-type ALU decode vectors
        for (int k = 0; k < 5; k++) begin
            opcode = v_op[k]; funct3 = v_f3[k]; funct7b5 = v_f7[k];
            tick; tick;
            check("alu_dec", 32'({state_dbg, alu_ctrl}), 32'({v_st[k], v_alu[k]}));
            tick; tick;
        end
        funct7b5 = 1'b0;
        check("alu_instret", instret_cnt, 32'd10);

        // illegal opcode: sticky trap, no strobes, cycle counter keeps running
        c0 = cycle_cnt; i0 = instret_cnt;
        opcode = 7'h7F;
        tick; tick;
        for (int i = 0; i < 20; i++) begin
            check("trap_hold", 32'({state_dbg, trap, strobes}), 32'({4'd15, 1'b1, 6'b000000}));
            tick;
        end
        check("trap_cycles", cycle_cnt - c0, 32'd22);
        check("trap_instret", instret_cnt, i0);
        rst = 1'b1;
        tick;
        rst = 1'b0; #1;
        check("trap_clr", 32'({state_dbg, trap}), 32'({4'd0, 1'b0}));
        check("trap_clr_cnt", cycle_cnt | instret_cnt, 32'd0);

        // store stalled in MEMWR, then reset mid-access
        opcode = 7'b0100011; funct3 = 3'b010; mem_ready = 1'b1;
        tick; tick;
        mem_ready = 1'b0;
        tick;
        check("sw_memwr", 32'({state_dbg, strobes, adr_src}), 32'({4'd5, 6'b110000, 1'b1}));
        tick;
        check("sw_stall", 32'({state_dbg, strobes}), 32'({4'd5, 6'b110000}));
        rst = 1'b1; #1;
        check("sw_rst_strobes", 32'(strobes), 32'h0);
        tick;
        rst = 1'b0; #1;
        check("sw_rel_state", 32'(state_dbg), 32'(S_FETCH));
        check("sw_rel_cnt", cycle_cnt | instret_cnt, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
